instruction_fetch_unit: RTL and testbench

Fetch stage of the pipelined RV64 CPU. It owns the architectural fetch PC and issues one instruction-memory request at a time. It buffers the returned 32-bit instruction and presents it, with its PC, to the IF/ID pipeline register, which samples it on every clock edge where stall is low. It honours the shared hazard stall and a branch/jump redirect from execute.

---
 rtl/rv64_fetch_pkg.sv | 31 +++
 rtl/fetch_out_buffer.sv | 66 ++++++
 rtl/instruction_fetch_unit.sv | 119 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv64_fetch_pkg.sv
// -----------------------------------------------------------------------------
// rv64_fetch_pkg
// Shared definitions for the RV64 instruction fetch stage:
//   fetch_state_e  - request/response sequencing states of the fetch FSM
//   fetch_entry_t  - one {valid, pc, inst} entry presented to IF/ID
//   NOP_INST       - bubble instruction (addi x0,x0,0), zero-extended to 64 bits
//   INST_BYTES     - byte stride between sequential instructions
//   align_pc()     - clears the low two address bits of a target address
// -----------------------------------------------------------------------------
package rv64_fetch_pkg;

  localparam logic [63:0] NOP_INST   = 64'h0000_0000_0000_0013;
  localparam logic [63:0] INST_BYTES = 64'd4;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,  // may issue a request at fetch_pc
    S_WAIT = 2'd1,  // one request outstanding, response will be kept
    S_DROP = 2'd2   // one request outstanding, response will be discarded
  } fetch_state_e;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [63:0] inst;
  } fetch_entry_t;

  function automatic logic [63:0] align_pc(input logic [63:0] addr);
    return {addr[63:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_out_buffer.sv
// -----------------------------------------------------------------------------
// fetch_out_buffer
// Single-entry holding register for the fetched {pc, inst, valid} presented to
// the IF/ID pipeline register. An empty entry drives pc=0 and inst=NOP.
// Ports:
//   clk, rst       - pipeline clock, synchronous active-high reset
//   fill_i         - load the entry with fill_pc_i / zero-extended fill_inst_i
//   fill_pc_i      - PC of the instruction being loaded
//   fill_inst_i    - 32-bit instruction word being loaded
//   consume_i      - IF/ID samples this edge (stall low); entry empties
//   flush_i        - redirect; entry empties, wins over fill and consume
//   pc_o, inst_o   - entry contents toward IF/ID
//   valid_o        - entry holds a real fetch
// -----------------------------------------------------------------------------
module fetch_out_buffer #(
  parameter logic [63:0] NOP_WORD = 64'h0000_0000_0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fill_i,
  input  logic [63:0] fill_pc_i,
  input  logic [31:0] fill_inst_i,
  input  logic        consume_i,
  input  logic        flush_i,
  output logic [63:0] pc_o,
  output logic [63:0] inst_o,
  output logic        valid_o
);
  import rv64_fetch_pkg::*;

  localparam fetch_entry_t EMPTY_ENTRY = '{valid: 1'b0, pc: 64'd0, inst: NOP_WORD};

  fetch_entry_t entry_q, entry_d;

  // Priority low to high: consume, fill (same-edge refill keeps the entry
  // valid), flush.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default first, otherwise a latch is inferred.
    entry_d = entry_q;
    if (consume_i) begin
      entry_d = EMPTY_ENTRY;
    end
    if (fill_i) begin
      entry_d.valid = 1'b1;
      entry_d.pc    = fill_pc_i;
      entry_d.inst  = {32'd0, fill_inst_i};
    end
    if (flush_i) begin
      entry_d = EMPTY_ENTRY;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      entry_q <= EMPTY_ENTRY;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign pc_o    = entry_q.pc;
  assign inst_o  = entry_q.inst;
  assign valid_o = entry_q.valid;

endmodule

// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
// Fetch stage of the pipelined RV64 CPU. Owns the fetch PC, issues at most one
// instruction-memory request at a time, buffers the returned word and presents
// it with its PC to IF/ID. Honours the shared hazard stall and execute-stage
// redirects.
// Ports:
//   clk, rst        - pipeline clock, synchronous active-high reset
//   stall           - shared hazard stall; low at an edge means IF/ID consumes
//   redirect_valid  - one-cycle flush/refetch pulse
//   redirect_pc     - redirect target (low two bits ignored)
//   imem_req_valid  - request valid toward instruction memory
//   imem_req_ready  - memory accepts the request
//   imem_req_addr   - request address
//   imem_rsp_valid  - single-cycle response strobe
//   imem_rsp_data   - fetched 32-bit instruction
//   pc, inst        - PC and zero-extended instruction toward IF/ID
//   inst_valid      - pc/inst hold a real fetch
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000,
  parameter logic [63:0] NOP_INST = 64'h0000_0000_0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [63:0] pc,
  output logic [63:0] inst,
  output logic        inst_valid
);
  import rv64_fetch_pkg::*;

  fetch_state_e state_q, state_d;
  logic [63:0]  fetch_pc_q, fetch_pc_d;
  logic [63:0]  req_pc_q, req_pc_d;
  logic         buf_fill;

  // Next-state and request logic.
  always_comb begin
    state_d        = state_q;
    fetch_pc_d     = fetch_pc_q;
    req_pc_d       = req_pc_q;
    imem_req_valid = 1'b0;
    buf_fill       = 1'b0;

    unique case (state_q)
      S_REQ: begin
        // Issue only when the buffer is empty or drains at this edge, so a
        // response always finds the buffer free. Because an empty buffer
        // stays empty in S_REQ, a raised request stays raised until accepted.
        imem_req_valid = (!inst_valid || !stall) && !redirect_valid && !rst;
        if (imem_req_valid && imem_req_ready) begin
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + INST_BYTES;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          buf_fill = !redirect_valid;
          state_d  = S_REQ;
        end else if (redirect_valid) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        // A redirect here re-targets fetch_pc only; the response still
        // pending (or arriving now) is the one being discarded.
        if (imem_rsp_valid) begin
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase

    if (redirect_valid) begin
      fetch_pc_d = align_pc(redirect_pc);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= 64'd0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
    end
  end

  assign imem_req_addr = fetch_pc_q;

  fetch_out_buffer #(
    .NOP_WORD (NOP_INST)
  ) u_out_buf (
    .clk         (clk),
    .rst         (rst),
    .fill_i      (buf_fill),
    .fill_pc_i   (req_pc_q),
    .fill_inst_i (imem_rsp_data),
    .consume_i   (!stall),
    .flush_i     (redirect_valid),
    .pc_o        (pc),
    .inst_o      (inst),
    .valid_o     (inst_valid)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_unit
// Directed scenarios plus randomized traffic against a transaction-level model
// of the fetch stage (fetch address, outstanding/discard flags, one output slot).
// A behavioural memory answers each accepted request after a chosen latency.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_unit;

  localparam logic [63:0] RESET_PC = 64'h0;
  localparam logic [63:0] NOP      = 64'h0000_0000_0000_0013;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [63:0] pc;
  logic [63:0] inst;
  logic        inst_valid;

  instruction_fetch_unit #(
    .RESET_PC (RESET_PC),
    .NOP_INST (NOP)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .pc             (pc),
    .inst           (inst),
    .inst_valid     (inst_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  logic [63:0] m_pc;       // next address to fetch
  logic        m_out;      // a request is outstanding
  logic        m_drop;     // the outstanding response must be discarded
  logic [63:0] m_req_pc;   // address of the outstanding request
  logic        b_valid;    // output slot occupied
  logic [63:0] b_pc;
  logic [31:0] b_inst;

  // Expectations for the current cycle.
  logic        exp_req;
  logic [63:0] exp_addr;
  logic        exp_iv;
  logic [63:0] exp_pc;
  logic [63:0] exp_inst;

  // Behavioural memory.
  int          mem_cnt = 0;
  int          mem_lat = 1;
  logic [63:0] mem_addr = 64'd0;

  function automatic logic [31:0] word_of(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0000;
  endfunction

  // Apply inputs for one cycle and derive what the DUT should show.
  task automatic drive(input logic r, input logic st, input logic rv,
                       input logic [63:0] rpc, input logic rdy);
    rst            = r;
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_req_ready = rdy;
    imem_rsp_valid = (mem_cnt == 1);
    imem_rsp_data  = (mem_cnt == 1) ? word_of(mem_addr) : $urandom;
    exp_req  = !r && !m_out && (!b_valid || !st) && !rv;
    exp_addr = m_pc;
    exp_iv   = b_valid;
    exp_pc   = b_valid ? b_pc : 64'd0;
    exp_inst = b_valid ? {32'd0, b_inst} : NOP;
    #1;
  endtask

  // Move model and memory across the clock edge.
  task automatic advance();
    logic acc;
    logic rsp_in;
    acc = exp_req && imem_req_ready;
    if (rst) begin
      m_pc = RESET_PC; m_out = 1'b0; m_drop = 1'b0; b_valid = 1'b0;
    end else begin
      rsp_in = m_out && imem_rsp_valid;
      if (!stall) b_valid = 1'b0;
      if (rsp_in && !m_drop && !redirect_valid) begin
        b_valid = 1'b1; b_pc = m_req_pc; b_inst = imem_rsp_data;
      end
      if (redirect_valid) b_valid = 1'b0;
      if (rsp_in) begin m_out = 1'b0; m_drop = 1'b0; end
      if (acc) begin
        m_out = 1'b1; m_drop = 1'b0; m_req_pc = m_pc; m_pc = m_pc + 64'd4;
      end
      if (redirect_valid) begin
        if (m_out) m_drop = 1'b1;
        m_pc = {redirect_pc[63:2], 2'b00};
      end
    end
    if (mem_cnt > 0) mem_cnt--;
    if (imem_req_valid && imem_req_ready) begin
      mem_cnt  = mem_lat;
      mem_addr = imem_req_addr;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 1'b0, 64'd0, 1'b1);
    advance();
    // Reset must win over a simultaneous redirect.
    drive(1'b1, 1'b0, 1'b1, 64'h0000_0000_1234_5670, 1'b1);
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL rst_inst_valid: got %b want 0", inst_valid); end
    n_cmp++; if (pc !== 64'd0) begin n_bad++; $display("FAIL rst_pc: got %h want 0", pc); end
    n_cmp++; if (inst !== NOP) begin n_bad++; $display("FAIL rst_inst: got %h want %h", inst, NOP); end
    advance();
    drive(1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
    n_cmp++; if (imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL rst_first_req: got %b want 1", imem_req_valid); end
    n_cmp++; if (imem_req_addr !== RESET_PC) begin n_bad++; $display("FAIL rst_first_addr: got %h want %h", imem_req_addr, RESET_PC); end
    advance();
  endtask

  task automatic test_sequential();
    logic [63:0] acc_q[$];
    logic [63:0] pcv_q[$];
    logic [63:0] insv_q[$];
    mem_lat = 1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, 1'b0, 64'd0, 1'b1);
      n_cmp++; if (imem_req_valid !== exp_req) begin n_bad++; $display("FAIL seq_req_valid c%0d: got %b want %b", i, imem_req_valid, exp_req); end
      n_cmp++; if (inst_valid !== exp_iv || pc !== exp_pc || inst !== exp_inst) begin
        n_bad++; $display("FAIL seq_out c%0d: got %b/%h/%h want %b/%h/%h", i, inst_valid, pc, inst, exp_iv, exp_pc, exp_inst);
      end
      if (imem_req_valid) acc_q.push_back(imem_req_addr);
      if (inst_valid) begin pcv_q.push_back(pc); insv_q.push_back(inst); end
      advance();
    end
    n_cmp++;
    if (acc_q.size() < 3 || pcv_q.size() < 2) begin
      n_bad++; $display("FAIL seq_count: got %0d req/%0d out want 3/2", acc_q.size(), pcv_q.size());
    end else begin
      if (acc_q[0] !== 64'h0 || acc_q[1] !== 64'h4 || acc_q[2] !== 64'h8) begin
        n_bad++; $display("FAIL seq_addrs: got %h %h %h want 0 4 8", acc_q[0], acc_q[1], acc_q[2]);
      end
      n_cmp++; if (pcv_q[0] !== 64'h0 || insv_q[0] !== {32'd0, word_of(64'h0)}) begin
        n_bad++; $display("FAIL seq_out0: got %h/%h want 0/%h", pcv_q[0], insv_q[0], word_of(64'h0));
      end
      n_cmp++; if (pcv_q[1] !== 64'h4 || insv_q[1] !== {32'd0, word_of(64'h4)}) begin
        n_bad++; $display("FAIL seq_out1: got %h/%h want 4/%h", pcv_q[1], insv_q[1], word_of(64'h4));
      end
    end
  endtask

  task automatic test_stall();
    bit found = 0;
    for (int i = 0; i < 10; i++) begin
      if (b_valid && b_pc == 64'h8) begin found = 1; break; end
      drive(1'b0, 1'b0, 1'b0, 64'd0, 1'b1);
      advance();
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL stall_setup: got timeout want slot with pc 8"); end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 1'b0, 64'd0, 1'b1);
      n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL stall_req c%0d: got %b want 0", i, imem_req_valid); end
      n_cmp++; if (inst_valid !== 1'b1 || pc !== 64'h8 || inst !== {32'd0, word_of(64'h8)}) begin
        n_bad++; $display("FAIL stall_hold c%0d: got %b/%h/%h want 1/8/%h", i, inst_valid, pc, inst, word_of(64'h8));
      end
      advance();
    end
    drive(1'b0, 1'b0, 1'b0, 64'd0, 1'b1);
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'hC) begin
      n_bad++; $display("FAIL stall_release: got %b/%h want 1/c", imem_req_valid, imem_req_addr);
    end
    advance();
  endtask

  task automatic test_ready();
    bit found = 0;
    for (int i = 0; i < 10; i++) begin
      if (!m_out && m_pc == 64'h10) begin found = 1; break; end
      drive(1'b0, 1'b0, 1'b0, 64'd0, 1'b1);
      advance();
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL ready_setup: got timeout want idle at 0x10"); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
      n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h10) begin
        n_bad++; $display("FAIL ready_hold c%0d: got %b/%h want 1/10", i, imem_req_valid, imem_req_addr);
      end
      advance();
    end
    drive(1'b0, 1'b0, 1'b0, 64'd0, 1'b1);
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h10) begin
      n_bad++; $display("FAIL ready_accept: got %b/%h want 1/10", imem_req_valid, imem_req_addr);
    end
    advance();
    found = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 1'b0, 64'd0, 1'b1);
      if (imem_req_valid) begin
        found = 1;
        n_cmp++; if (imem_req_addr !== 64'h14) begin n_bad++; $display("FAIL ready_next: got %h want 14", imem_req_addr); end
        advance();
        break;
      end
      advance();
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL ready_next_timeout: got none want request at 0x14"); end
  endtask

  task automatic test_redirect_wait();
    bit found = 0;
    mem_lat = 2;
    for (int i = 0; i < 10; i++) begin
      if (m_out && mem_cnt == 2) begin found = 1; break; end
      drive(1'b0, 1'b0, 1'b0, 64'd0, 1'b1);
      advance();
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL rdw_setup: got timeout want fresh outstanding request"); end
    drive(1'b0, 1'b0, 1'b1, 64'h2001, 1'b1);
    advance();
    found = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 1'b0, 64'd0, 1'b1);
      n_cmp++; if (inst_valid !== 1'b0 || inst !== NOP) begin
        n_bad++; $display("FAIL rdw_bubble c%0d: got %b/%h want 0/%h", i, inst_valid, inst, NOP);
      end
      if (imem_req_valid) begin
        found = 1;
        n_cmp++; if (imem_req_addr !== 64'h2000) begin n_bad++; $display("FAIL rdw_addr: got %h want 2000", imem_req_addr); end
        advance();
        break;
      end
      advance();
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL rdw_req_timeout: got none want request at 0x2000"); end
    found = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 1'b0, 64'd0, 1'b1);
      if (inst_valid) begin
        found = 1;
        n_cmp++; if (pc !== 64'h2000 || inst !== {32'd0, word_of(64'h2000)}) begin
          n_bad++; $display("FAIL rdw_out: got %h/%h want 2000/%h", pc, inst, word_of(64'h2000));
        end
        advance();
        break;
      end
      advance();
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL rdw_out_timeout: got none want word at 0x2000"); end
  endtask

  task automatic test_redirect_rsp_stall();
    bit found = 0;
    logic [63:0] tgt;
    tgt = 64'h4000_0000_0000_0ABE;
    mem_lat = 1;
    for (int i = 0; i < 10; i++) begin
      if (m_out && mem_cnt == 1) begin found = 1; break; end
      drive(1'b0, 1'b0, 1'b0, 64'd0, 1'b1);
      advance();
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL rrs_setup: got timeout want response due"); end
    drive(1'b0, 1'b1, 1'b1, tgt, 1'b1);
    advance();
    drive(1'b0, 1'b1, 1'b0, 64'd0, 1'b0);
    n_cmp++; if (inst_valid !== 1'b0 || pc !== 64'd0 || inst !== NOP) begin
      n_bad++; $display("FAIL rrs_flush: got %b/%h/%h want 0/0/%h", inst_valid, pc, inst, NOP);
    end
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h4000_0000_0000_0ABC) begin
      n_bad++; $display("FAIL rrs_req: got %b/%h want 1/4000000000000abc", imem_req_valid, imem_req_addr);
    end
    advance();
  endtask

  task automatic test_wrap_reset();
    bit found = 0;
    drive(1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    advance();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b0, 64'd0, 1'b1);
      if (imem_req_valid) begin
        found = 1;
        n_cmp++; if (imem_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_bad++; $display("FAIL wrap_top: got %h want fffffffffffffffc", imem_req_addr); end
        advance();
        break;
      end
      advance();
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL wrap_top_timeout: got none want request"); end
    mem_lat = 2;
    found = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 1'b0, 64'd0, 1'b1);
      if (imem_req_valid) begin
        found = 1;
        n_cmp++; if (imem_req_addr !== 64'h0) begin n_bad++; $display("FAIL wrap_zero: got %h want 0", imem_req_addr); end
        advance();
        break;
      end
      advance();
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL wrap_zero_timeout: got none want request"); end
    // Reset lands while the 0x0 request is outstanding; its response follows.
    drive(1'b1, 1'b0, 1'b0, 64'd0, 1'b1);
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL wrap_rst_req: got %b want 0", imem_req_valid); end
    advance();
    drive(1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC || inst_valid !== 1'b0) begin
      n_bad++; $display("FAIL wrap_rst_after: got %b/%h/%b want 1/%h/0", imem_req_valid, imem_req_addr, inst_valid, RESET_PC);
    end
    advance();
    drive(1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
    n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL wrap_stale_rsp: got %b want 0", inst_valid); end
    advance();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      mem_lat = $urandom_range(1, 3);
      drive(($urandom % 100) < 2, ($urandom % 100) < 30, ($urandom % 100) < 6,
            {$urandom, $urandom}, ($urandom % 100) < 70);
      n_cmp++; if (imem_req_valid !== exp_req) begin n_bad++; $display("FAIL rnd_req_valid c%0d: got %b want %b", i, imem_req_valid, exp_req); end
      if (exp_req) begin
        n_cmp++; if (imem_req_addr !== exp_addr) begin n_bad++; $display("FAIL rnd_addr c%0d: got %h want %h", i, imem_req_addr, exp_addr); end
      end
      n_cmp++; if (inst_valid !== exp_iv || pc !== exp_pc || inst !== exp_inst) begin
        n_bad++; $display("FAIL rnd_out c%0d: got %b/%h/%h want %b/%h/%h", i, inst_valid, pc, inst, exp_iv, exp_pc, exp_inst);
      end
      advance();
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 64'd0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
    m_pc = RESET_PC; m_out = 1'b0; m_drop = 1'b0; m_req_pc = 64'd0;
    b_valid = 1'b0; b_pc = 64'd0; b_inst = 32'd0;
    test_reset();
    test_sequential();
    test_stall();
    test_ready();
    test_redirect_wait();
    test_redirect_rsp_stall();
    test_wrap_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
